// File: rtl/basic_ops_pkg.sv
// Shared op codes and types for the registered basic-operators block.
package basic_ops_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NAND = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_NOTA = 3'b110;
  localparam op_t OP_PASS = 3'b111;

endpackage

// File: rtl/basic_logic_core.sv
// Purely combinational WIDTH-bit bitwise operator, 8-way op select.
module basic_logic_core
  import basic_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/basic_ops_reg.sv
// Registered bitwise operator with valid/ready handshake, accumulator and
// saturating op counter. Define BASIC_OPS_PARITY_EN to add the parity output.
module basic_ops_reg
  import basic_ops_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  op_t                  op,
  input  logic                 acc_mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 zero,
  output logic [CNT_WIDTH-1:0] op_count
`ifdef BASIC_OPS_PARITY_EN
  ,
  output logic                 parity
`endif
);

  logic                 r_valid;
  logic [WIDTH-1:0]     r_y;
  logic                 r_zero;
  logic [WIDTH-1:0]     r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_acc_eff;
  logic [WIDTH-1:0]     w_opb;
  logic [WIDTH-1:0]     w_result;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A same-cycle clear must be visible to the op it accompanies.
  assign w_acc_eff = acc_clr ? '0 : r_acc;
  assign w_opb     = acc_mode ? w_acc_eff : b;

  basic_logic_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (w_opb),
    .op     (op),
    .result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_zero  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_y     <= w_result;
        r_zero  <= (w_result == '0);
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept && acc_mode) begin
        r_acc <= w_result;
      end else if (acc_clr) begin
        r_acc <= '0;
      end

      if (w_accept && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

`ifdef BASIC_OPS_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^w_result;
    end
  end

  assign parity = r_parity;
`endif

  assign out_valid = r_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_basic_ops_reg.sv
// Directed, table-driven bench for basic_ops_reg (8/8 instance plus a
// CNT_WIDTH=2 instance for counter saturation and mid-stream reset).
module tb_basic_ops_reg;
  import basic_ops_pkg::*;

  logic       clk = 1'b0;
  logic       rst, s_rst;
  logic       in_valid, s_in_valid;
  logic       in_ready, s_in_ready;
  logic [7:0] a, b;
  op_t        op;
  logic       acc_mode, acc_clr, out_ready;
  logic       out_valid, s_out_valid;
  logic [7:0] y, s_y;
  logic       zero, s_zero;
  logic [7:0] op_count;
  logic [1:0] s_op_count;
`ifdef BASIC_OPS_PARITY_EN
  logic       parity, s_parity;
`endif

  always #5 clk = ~clk;

  basic_ops_reg #(.WIDTH(8), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
    .op_count(op_count)
`ifdef BASIC_OPS_PARITY_EN
    , .parity(parity)
`endif
  );

  basic_ops_reg #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y), .zero(s_zero),
    .op_count(s_op_count)
`ifdef BASIC_OPS_PARITY_EN
    , .parity(s_parity)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    op_t        op;
    logic       am;
    logic       ac;
    logic [7:0] ey;
    logic       ez;
  } vec_t;

  vec_t tv[18];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sweep a=F0 b=CC over all ops
    tv[0]  = '{8'hF0, 8'hCC, OP_AND,  1'b0, 1'b0, 8'hC0, 1'b0};
    tv[1]  = '{8'hF0, 8'hCC, OP_OR,   1'b0, 1'b0, 8'hFC, 1'b0};
    tv[2]  = '{8'hF0, 8'hCC, OP_XOR,  1'b0, 1'b0, 8'h3C, 1'b0};
    tv[3]  = '{8'hF0, 8'hCC, OP_NAND, 1'b0, 1'b0, 8'h3F, 1'b0};
    tv[4]  = '{8'hF0, 8'hCC, OP_NOR,  1'b0, 1'b0, 8'h03, 1'b0};
    tv[5]  = '{8'hF0, 8'hCC, OP_XNOR, 1'b0, 1'b0, 8'hC3, 1'b0};
    tv[6]  = '{8'hF0, 8'hCC, OP_NOTA, 1'b0, 1'b0, 8'h0F, 1'b0};
    tv[7]  = '{8'hF0, 8'hCC, OP_PASS, 1'b0, 1'b0, 8'hF0, 1'b0};
    // Zero flag, with acc_clr riding along on a non-acc op
    tv[8]  = '{8'hAA, 8'hAA, OP_XOR,  1'b0, 1'b1, 8'h00, 1'b1};
    tv[9]  = '{8'hFF, 8'h01, OP_AND,  1'b0, 1'b0, 8'h01, 1'b0};
    // Accumulator chain
    tv[10] = '{8'h01, 8'h00, OP_OR,   1'b1, 1'b0, 8'h01, 1'b0};
    tv[11] = '{8'h02, 8'h00, OP_OR,   1'b1, 1'b0, 8'h03, 1'b0};
    tv[12] = '{8'h04, 8'h00, OP_OR,   1'b1, 1'b0, 8'h07, 1'b0};
    tv[13] = '{8'h80, 8'h00, OP_OR,   1'b1, 1'b1, 8'h80, 1'b0};
    tv[14] = '{8'h01, 8'hFF, OP_OR,   1'b1, 1'b0, 8'h81, 1'b0};
    tv[15] = '{8'hFF, 8'h00, OP_AND,  1'b1, 1'b0, 8'h81, 1'b0};
    tv[16] = '{8'hFF, 8'h0F, OP_AND,  1'b0, 1'b0, 8'h0F, 1'b0};
    tv[17] = '{8'h00, 8'h00, OP_OR,   1'b1, 1'b0, 8'h81, 1'b0};

    rst = 1'b1; s_rst = 1'b1; in_valid = 1'b0; s_in_valid = 1'b0;
    a = '0; b = '0; op = OP_AND; acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_y",         32'(y),         32'd0);
    chk("reset_zero",      32'(zero),      32'd0);
    chk("reset_op_count",  32'(op_count),  32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    tick();
    chk("idle_op_count",   32'(op_count),  32'd0);

    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      a = tv[i].a; b = tv[i].b; op = tv[i].op;
      acc_mode = tv[i].am; acc_clr = tv[i].ac;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_y", i),         32'(y),         32'(tv[i].ey));
      chk($sformatf("vec%0d_zero", i),      32'(zero),      32'(tv[i].ez));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
`ifdef BASIC_OPS_PARITY_EN
      chk($sformatf("vec%0d_parity", i),    32'(parity),    32'(^tv[i].ey));
`endif
      if (i == 7) chk("sweep_op_count", 32'(op_count), 32'd8);
    end
    chk("table_op_count", 32'(op_count), 32'd18);
    acc_mode = 1'b0; acc_clr = 1'b0;

    // Backpressure: one accept, then hold out_ready low for 5 cycles
    a = 8'h55; b = 8'h0F; op = OP_AND; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("bp_first_y", 32'(y), 32'h05);
    out_ready = 1'b0; op = OP_OR;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_y", k),     32'(y),         32'h05);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_cnt", k),   32'(op_count),  32'd19);
      chk($sformatf("bp_hold%0d_rdy", k),   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_release_y",   32'(y),         32'h5F);
    chk("bp_release_cnt", 32'(op_count),  32'd20);
    chk("bp_release_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_y_kept",    32'(y),         32'h5F);
    chk("drain_op_count",  32'(op_count),  32'd20);

`ifdef BASIC_OPS_PARITY_EN
    in_valid = 1'b1; op = OP_PASS; a = 8'h07;
    tick();
    chk("parity_07", 32'(parity), 32'd1);
    a = 8'h03;
    tick();
    chk("parity_03", 32'(parity), 32'd0);
    in_valid = 1'b0;
    tick();
`endif

    // Saturation on the 2-bit counter instance
    in_valid = 1'b0; out_ready = 1'b1; op = OP_PASS; a = 8'h3C;
    s_in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("sat%0d_op_count", k), 32'(s_op_count), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    chk("sat_y",         32'(s_y),         32'h3C);
    chk("sat_in_ready",  32'(s_in_ready),  32'd1);
    chk("sat_out_valid", 32'(s_out_valid), 32'd1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0; s_in_valid = 1'b0;
    chk("midrst_out_valid", 32'(s_out_valid), 32'd0);
    chk("midrst_op_count",  32'(s_op_count),  32'd0);
    chk("midrst_y",         32'(s_y),         32'd0);
    chk("midrst_zero",      32'(s_zero),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
